// File: rtl/packet_loader_pkg.sv
// Shared types, field positions and the request/packet merge rule for the packet loader.
// No timing of its own; the merge function is purely combinational.
// No flow control lives here.
package packet_loader_pkg;

  localparam int PACKET_WIDTH         = 160;
  localparam int PACKET_REQUEST_WIDTH = 99;

  // Index of the last of the five memory words that make up one packet
  localparam logic [2:0] LAST_WORD = 3'd4;

  // Opmode values: select which unit receives the finished packet
  localparam logic [1:0] OPCODE_EI = 2'd0;
  localparam logic [1:0] OPCODE_FN = 2'd1;
  localparam logic [1:0] OPCODE_MA = 2'd2;

  // Destination options carried in the request
  localparam logic [2:0] DEST_OPTION_EXEC  = 3'd0;
  localparam logic [2:0] DEST_OPTION_ONE   = 3'd1;
  localparam logic [2:0] DEST_OPTION_LEFT  = 3'd2;
  localparam logic [2:0] DEST_OPTION_RIGHT = 3'd3;

  // Packet field positions
  localparam int PKT_OPMODE_HI = 159;
  localparam int PKT_OPMODE_LO = 158;
  localparam int PKT_COLOR_HI  = 143;
  localparam int PKT_COLOR_LO  = 128;
  localparam int PKT_DATA1_HI  = 127;
  localparam int PKT_DATA1_LO  = 96;
  localparam int PKT_DATA2_HI  = 95;
  localparam int PKT_DATA2_LO  = 64;

  // Request field positions
  localparam int REQ_DOPT_HI  = 98;
  localparam int REQ_DOPT_LO  = 96;
  localparam int REQ_DADDR_HI = 95;
  localparam int REQ_DADDR_LO = 80;
  localparam int REQ_COLOR_HI = 79;
  localparam int REQ_COLOR_LO = 64;
  localparam int REQ_DA_HI    = 63;
  localparam int REQ_DA_LO    = 32;
  localparam int REQ_DB_HI    = 31;
  localparam int REQ_DB_LO    = 0;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, SEND} state_e;

  // Overlay the request's color and operands onto the packet image read from memory
  function automatic logic [PACKET_WIDTH-1:0] merge_packet(
    input logic [PACKET_WIDTH-1:0]         loaded,
    input logic [PACKET_REQUEST_WIDTH-1:0] req
  );
    logic [PACKET_WIDTH-1:0] pkt;
    logic [2:0]              opt;
    logic [31:0]             da;
    logic [31:0]             db;
    pkt = loaded;
    opt = req[REQ_DOPT_HI:REQ_DOPT_LO];
    da  = req[REQ_DA_HI:REQ_DA_LO];
    db  = req[REQ_DB_HI:REQ_DB_LO];
    pkt[PKT_COLOR_HI:PKT_COLOR_LO] = req[REQ_COLOR_HI:REQ_COLOR_LO];
    case (opt)
      DEST_OPTION_ONE, DEST_OPTION_LEFT: pkt[PKT_DATA1_HI:PKT_DATA1_LO] = da;
      DEST_OPTION_RIGHT:                 pkt[PKT_DATA2_HI:PKT_DATA2_LO] = da;
      DEST_OPTION_EXEC: begin
        pkt[PKT_DATA1_HI:PKT_DATA1_LO] = da;
        pkt[PKT_DATA2_HI:PKT_DATA2_LO] = db;
      end
      // Reserved codes 4-7 behave like EXEC
      default: begin
        pkt[PKT_DATA1_HI:PKT_DATA1_LO] = da;
        pkt[PKT_DATA2_HI:PKT_DATA2_LO] = db;
      end
    endcase
    return pkt;
  endfunction

endpackage

// File: rtl/packet_loader_merge.sv
// Combines the loaded packet image with the latched request.
// Zero latency (pure combinational).
// No flow control; the caller decides when the result is captured.
module packet_merge
  import packet_loader_pkg::*;
(
  input  logic [PACKET_WIDTH-1:0]         loaded_pkt,
  input  logic [PACKET_REQUEST_WIDTH-1:0] req,
  output logic [PACKET_WIDTH-1:0]         merged_pkt
);

  assign merged_pkt = merge_packet(loaded_pkt, req);

endmodule

// File: rtl/packet_loader.sv
// Accepts a packet request, reads five words from memory and routes the merged packet by opmode.
// Latency: five serial read round trips plus one cycle; all outputs are registered.
// One read outstanding at a time; no request accepted until the current packet leaves or is dropped.
module packet_loader
  import packet_loader_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [31:0]                     opaddr,
  output logic                            mem_send_addr_valid,
  output logic [31:0]                     mem_send_addr,
  output logic                            mem_send_data_valid,
  output logic [31:0]                     mem_send_data,
  input  logic                            mem_send_ready,
  input  logic                            mem_receive_valid,
  input  logic [31:0]                     mem_receive_data,
  output logic                            mem_receive_ready,
  input  logic                            receive_pr_valid,
  input  logic [PACKET_REQUEST_WIDTH-1:0] receive_pr_data,
  output logic                            receive_pr_ready,
  output logic                            send_pc_to_qu_valid,
  output logic [PACKET_WIDTH-1:0]         send_pc_to_qu_data,
  input  logic                            send_pc_to_qu_ready,
  output logic                            send_pc_to_fe_valid,
  output logic [PACKET_WIDTH-1:0]         send_pc_to_fe_data,
  input  logic                            send_pc_to_fe_ready,
  output logic                            send_pc_to_ma_valid,
  output logic [PACKET_WIDTH-1:0]         send_pc_to_ma_data,
  input  logic                            send_pc_to_ma_ready
);

  state_e                          state;
  logic [2:0]                      k;
  logic [PACKET_REQUEST_WIDTH-1:0] req;
  logic [127:0]                    words;
  logic [PACKET_WIDTH-1:0]         out_pkt;
  logic [PACKET_WIDTH-1:0]         loaded;
  logic [PACKET_WIDTH-1:0]         merged;
  logic [1:0]                      merged_opmode;
  logic                            out_taken;

  // Byte address of word idx of the packet image, wrapping modulo 2^32
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] daddr,
                                            input logic [2:0] idx);
    return base + {16'd0, daddr} + {27'd0, idx, 2'b00};
  endfunction

  // The block never writes memory
  assign mem_send_data_valid = 1'b0;
  assign mem_send_data       = 32'd0;

  // One packet register feeds all three ports; only the selected port's valid is raised
  assign send_pc_to_qu_data = out_pkt;
  assign send_pc_to_fe_data = out_pkt;
  assign send_pc_to_ma_data = out_pkt;

  // The fifth word is merged straight off the return bus so the packet is ready on its arrival
  assign loaded        = {words, mem_receive_data};
  assign merged_opmode = merged[PKT_OPMODE_HI:PKT_OPMODE_LO];
  assign out_taken     = (send_pc_to_qu_valid && send_pc_to_qu_ready) ||
                         (send_pc_to_fe_valid && send_pc_to_fe_ready) ||
                         (send_pc_to_ma_valid && send_pc_to_ma_ready);

  packet_merge u_merge (
    .loaded_pkt (loaded),
    .req        (req),
    .merged_pkt (merged)
  );

  // Load sequencer: request capture, five serial reads, then routing or discard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      k                   <= 3'd0;
      req                 <= '0;
      words               <= '0;
      out_pkt             <= '0;
      mem_send_addr_valid <= 1'b0;
      mem_send_addr       <= 32'd0;
      mem_receive_ready   <= 1'b0;
      receive_pr_ready    <= 1'b0;
      send_pc_to_qu_valid <= 1'b0;
      send_pc_to_fe_valid <= 1'b0;
      send_pc_to_ma_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          receive_pr_ready <= 1'b1;
          if (receive_pr_valid && receive_pr_ready) begin
            req                 <= receive_pr_data;
            k                   <= 3'd0;
            receive_pr_ready    <= 1'b0;
            mem_send_addr_valid <= 1'b1;
            mem_send_addr       <= word_addr(opaddr, receive_pr_data[REQ_DADDR_HI:REQ_DADDR_LO], 3'd0);
            state               <= ADDR;
          end
        end
        ADDR: begin
          if (mem_send_addr_valid && mem_send_ready) begin
            mem_send_addr_valid <= 1'b0;
            mem_receive_ready   <= 1'b1;
            state               <= DATA;
          end
        end
        DATA: begin
          if (mem_receive_valid && mem_receive_ready) begin
            mem_receive_ready <= 1'b0;
            if (k != LAST_WORD) begin
              case (k)
                3'd0:    words[127:96] <= mem_receive_data;
                3'd1:    words[95:64]  <= mem_receive_data;
                3'd2:    words[63:32]  <= mem_receive_data;
                default: words[31:0]   <= mem_receive_data;
              endcase
              k                   <= k + 3'd1;
              mem_send_addr_valid <= 1'b1;
              mem_send_addr       <= word_addr(opaddr, req[REQ_DADDR_HI:REQ_DADDR_LO], k + 3'd1);
              state               <= ADDR;
            end else begin
              out_pkt <= merged;
              case (merged_opmode)
                OPCODE_EI: send_pc_to_qu_valid <= 1'b1;
                OPCODE_FN: send_pc_to_fe_valid <= 1'b1;
                OPCODE_MA: send_pc_to_ma_valid <= 1'b1;
                default:   ;
              endcase
              // Opmode 3 has no destination: drop the packet and reopen for requests
              if (merged_opmode == 2'd3) begin
                receive_pr_ready <= 1'b1;
                state            <= IDLE;
              end else begin
                state <= SEND;
              end
            end
          end
        end
        SEND: begin
          if (out_taken) begin
            send_pc_to_qu_valid <= 1'b0;
            send_pc_to_fe_valid <= 1'b0;
            send_pc_to_ma_valid <= 1'b0;
            receive_pr_ready    <= 1'b1;
            state               <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_loader.sv
// Directed bench for packet_loader: reset, address sequencing, merge, routing, stalls, discard.
// Inputs driven and outputs sampled on the falling clock edge.
// Memory and output ports modelled inline with fixed per-vector stall lengths.
module tb_packet_loader;

  logic         clk;
  logic         rst_n;
  logic [31:0]  opaddr;
  logic         mem_send_addr_valid;
  logic [31:0]  mem_send_addr;
  logic         mem_send_data_valid;
  logic [31:0]  mem_send_data;
  logic         mem_send_ready;
  logic         mem_receive_valid;
  logic [31:0]  mem_receive_data;
  logic         mem_receive_ready;
  logic         receive_pr_valid;
  logic [98:0]  receive_pr_data;
  logic         receive_pr_ready;
  logic         send_pc_to_qu_valid;
  logic [159:0] send_pc_to_qu_data;
  logic         send_pc_to_qu_ready;
  logic         send_pc_to_fe_valid;
  logic [159:0] send_pc_to_fe_data;
  logic         send_pc_to_fe_ready;
  logic         send_pc_to_ma_valid;
  logic [159:0] send_pc_to_ma_data;
  logic         send_pc_to_ma_ready;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] v_opaddr [6];
  logic [15:0] v_daddr  [6];
  logic [2:0]  v_opt    [6];
  logic [15:0] v_color  [6];
  logic [31:0] v_da     [6];
  logic [31:0] v_db     [6];
  logic [31:0] vw       [6][5];

  packet_loader dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .opaddr              (opaddr),
    .mem_send_addr_valid (mem_send_addr_valid),
    .mem_send_addr       (mem_send_addr),
    .mem_send_data_valid (mem_send_data_valid),
    .mem_send_data       (mem_send_data),
    .mem_send_ready      (mem_send_ready),
    .mem_receive_valid   (mem_receive_valid),
    .mem_receive_data    (mem_receive_data),
    .mem_receive_ready   (mem_receive_ready),
    .receive_pr_valid    (receive_pr_valid),
    .receive_pr_data     (receive_pr_data),
    .receive_pr_ready    (receive_pr_ready),
    .send_pc_to_qu_valid (send_pc_to_qu_valid),
    .send_pc_to_qu_data  (send_pc_to_qu_data),
    .send_pc_to_qu_ready (send_pc_to_qu_ready),
    .send_pc_to_fe_valid (send_pc_to_fe_valid),
    .send_pc_to_fe_data  (send_pc_to_fe_data),
    .send_pc_to_fe_ready (send_pc_to_fe_ready),
    .send_pc_to_ma_valid (send_pc_to_ma_valid),
    .send_pc_to_ma_data  (send_pc_to_ma_data),
    .send_pc_to_ma_ready (send_pc_to_ma_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Expected packet: memory words in order, then color and operands overlaid by dest option
  function automatic logic [159:0] model(input int v);
    logic [159:0] p;
    p = {vw[v][0], vw[v][1], vw[v][2], vw[v][3], vw[v][4]};
    p[143:128] = v_color[v];
    case (v_opt[v])
      3'd1, 3'd2: p[127:96] = v_da[v];
      3'd3:       p[95:64]  = v_da[v];
      default: begin
        p[127:96] = v_da[v];
        p[95:64]  = v_db[v];
      end
    endcase
    return p;
  endfunction

  function automatic logic [2:0] all_vld();
    return {send_pc_to_qu_valid, send_pc_to_fe_valid, send_pc_to_ma_valid};
  endfunction

  function automatic logic [159:0] sel_data(input logic [1:0] om);
    if (om == 2'd0) return send_pc_to_qu_data;
    if (om == 2'd1) return send_pc_to_fe_data;
    return send_pc_to_ma_data;
  endfunction

  task automatic send_req(input int v);
    int cnt;
    opaddr = v_opaddr[v];
    @(negedge clk);
    receive_pr_valid = 1'b1;
    receive_pr_data  = {v_opt[v], v_daddr[v], v_color[v], v_da[v], v_db[v]};
    cnt = 0;
    while (!receive_pr_ready && cnt < 50) begin @(negedge clk); cnt++; end
    chk("pr_rdy", 160'(receive_pr_ready), 160'(1));
    @(negedge clk);
    receive_pr_valid = 1'b0;
    receive_pr_data  = '0;
  endtask

  // One address handshake plus one data return for word i of vector v
  task automatic mem_word(input int v, input int i, input int stall);
    int cnt;
    int ns;
    logic [31:0] exp_addr;
    exp_addr = v_opaddr[v] + {16'd0, v_daddr[v]} + 32'(4 * i);
    cnt = 0;
    while (!mem_send_addr_valid && cnt < 50) begin @(negedge clk); cnt++; end
    chk("addr_vld", 160'(mem_send_addr_valid), 160'(1));
    ns = stall ? (i % 3) + 1 : 0;
    for (int s = 0; s < ns; s++) begin
      chk("addr_hold", 160'(mem_send_addr), 160'(exp_addr));
      @(negedge clk);
    end
    chk("addr", 160'(mem_send_addr), 160'(exp_addr));
    mem_send_ready = 1'b1;
    @(negedge clk);
    mem_send_ready = 1'b0;
    chk("one_outst", 160'({mem_send_addr_valid, mem_receive_ready}), 160'(2'b01));
    ns = stall ? ((i + 1) % 3) : 0;
    for (int s = 0; s < ns; s++) begin
      @(negedge clk);
      chk("no_new_addr", 160'(mem_send_addr_valid), 160'(0));
    end
    mem_receive_valid = 1'b1;
    mem_receive_data  = vw[v][i];
    cnt = 0;
    while (!mem_receive_ready && cnt < 50) begin @(negedge clk); cnt++; end
    chk("rcv_rdy", 160'(mem_receive_ready), 160'(1));
    @(negedge clk);
    mem_receive_valid = 1'b0;
    mem_receive_data  = 32'd0;
  endtask

  task automatic run_vec(input int v, input int stall);
    logic [159:0] exp_pkt;
    logic [1:0]   om;
    logic [2:0]   exp_sel;
    exp_pkt = model(v);
    om      = vw[v][0][31:30];
    case (om)
      2'd0:    exp_sel = 3'b100;
      2'd1:    exp_sel = 3'b010;
      2'd2:    exp_sel = 3'b001;
      default: exp_sel = 3'b000;
    endcase
    send_req(v);
    for (int i = 0; i < 5; i++) mem_word(v, i, stall);
    if (om == 2'd3) begin
      for (int c = 0; c < 4; c++) begin
        chk("disc_vld", 160'(all_vld()), 160'(0));
        @(negedge clk);
      end
      chk("disc_pr_rdy", 160'(receive_pr_ready), 160'(1));
    end else begin
      chk("out_sel", 160'(all_vld()), 160'(exp_sel));
      chk("out_dat", sel_data(om), exp_pkt);
      for (int s = 0; s < (stall ? 2 : 0); s++) begin
        @(negedge clk);
        chk("out_hold_sel", 160'(all_vld()), 160'(exp_sel));
        chk("out_hold_dat", sel_data(om), exp_pkt);
      end
      send_pc_to_qu_ready = (om == 2'd0);
      send_pc_to_fe_ready = (om == 2'd1);
      send_pc_to_ma_ready = (om == 2'd2);
      @(negedge clk);
      send_pc_to_qu_ready = 1'b0;
      send_pc_to_fe_ready = 1'b0;
      send_pc_to_ma_ready = 1'b0;
      chk("out_done", 160'(all_vld()), 160'(0));
      chk("idle_pr_rdy", 160'(receive_pr_ready), 160'(1));
    end
  endtask

  initial begin
    // Vector table: opaddr, dest_addr, dest_option, color, data_a, data_b, five memory words
    v_opaddr[0] = 32'h2000_0000; v_daddr[0] = 16'h0100; v_opt[0] = 3'd0; v_color[0] = 16'hBEEF;
    v_da[0] = 32'h1111_1111; v_db[0] = 32'h2222_2222;
    vw[0][0] = 32'h0A5B_C3D4; vw[0][1] = 32'h0123_4567; vw[0][2] = 32'h89AB_CDEF;
    vw[0][3] = 32'hDEAD_BEEF; vw[0][4] = 32'hCAFE_F00D;
    v_opaddr[1] = 32'h1000_0000; v_daddr[1] = 16'h0040; v_opt[1] = 3'd1; v_color[1] = 16'h1234;
    v_da[1] = 32'hA1A1_A1A1; v_db[1] = 32'hB2B2_B2B2;
    vw[1][0] = 32'h4123_4567; vw[1][1] = 32'h5555_AAAA; vw[1][2] = 32'h0F0F_0F0F;
    vw[1][3] = 32'hF0F0_F0F0; vw[1][4] = 32'h1357_9BDF;
    v_opaddr[2] = 32'h0000_1000; v_daddr[2] = 16'h8000; v_opt[2] = 3'd2; v_color[2] = 16'h00FF;
    v_da[2] = 32'h3C3C_3C3C; v_db[2] = 32'h4D4D_4D4D;
    vw[2][0] = 32'h8765_4321; vw[2][1] = 32'h2468_ACE0; vw[2][2] = 32'h1122_3344;
    vw[2][3] = 32'h5566_7788; vw[2][4] = 32'h99AA_BBCC;
    v_opaddr[3] = 32'hFFFF_FFF0; v_daddr[3] = 16'hFFFC; v_opt[3] = 3'd3; v_color[3] = 16'hFFFF;
    v_da[3] = 32'h7E7E_7E7E; v_db[3] = 32'h6B6B_6B6B;
    vw[3][0] = 32'h3FFF_FFFF; vw[3][1] = 32'h0000_0001; vw[3][2] = 32'h8000_0000;
    vw[3][3] = 32'h7FFF_FFFF; vw[3][4] = 32'hFFFF_FFFE;
    v_opaddr[4] = 32'h3000_0000; v_daddr[4] = 16'h0010; v_opt[4] = 3'd5; v_color[4] = 16'h0A0A;
    v_da[4] = 32'hC1C1_C1C1; v_db[4] = 32'hD2D2_D2D2;
    vw[4][0] = 32'hC000_0001; vw[4][1] = 32'h1000_0002; vw[4][2] = 32'h2000_0003;
    vw[4][3] = 32'h3000_0004; vw[4][4] = 32'h4000_0005;
    v_opaddr[5] = 32'h3000_0000; v_daddr[5] = 16'h0020; v_opt[5] = 3'd6; v_color[5] = 16'h5A5A;
    v_da[5] = 32'hE3E3_E3E3; v_db[5] = 32'hF4F4_F4F4;
    vw[5][0] = 32'h9000_0002; vw[5][1] = 32'hAAAA_5555; vw[5][2] = 32'h1234_5678;
    vw[5][3] = 32'h8765_4321; vw[5][4] = 32'h0BAD_CAFE;

    rst_n = 1'b0; opaddr = 32'd0;
    mem_send_ready = 1'b0; mem_receive_valid = 1'b0; mem_receive_data = 32'd0;
    receive_pr_valid = 1'b0; receive_pr_data = '0;
    send_pc_to_qu_ready = 1'b0; send_pc_to_fe_ready = 1'b0; send_pc_to_ma_ready = 1'b0;

    // Reset with every ready low
    repeat (3) @(negedge clk);
    chk("rst_pr_rdy", 160'(receive_pr_ready), 160'(0));
    chk("rst_vld", 160'({mem_send_addr_valid, mem_receive_ready, all_vld()}), 160'(0));
    chk("rst_addr", 160'(mem_send_addr), 160'(0));
    chk("rst_wr", 160'({mem_send_data_valid, mem_send_data}), 160'(0));
    chk("rst_pkt", send_pc_to_qu_data, 160'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_pr_rdy", 160'(receive_pr_ready), 160'(1));

    run_vec(0, 0);
    run_vec(1, 1);
    run_vec(2, 1);
    run_vec(3, 1);
    run_vec(4, 0);
    run_vec(5, 1);

    // Reset in the middle of a load, after the first word has returned
    send_req(2);
    mem_word(2, 0, 0);
    chk("mid_addr_vld", 160'(mem_send_addr_valid), 160'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 160'({mem_send_addr_valid, mem_receive_ready, all_vld()}), 160'(0));
    chk("mid_rst_pr_rdy", 160'(receive_pr_ready), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", 160'({mem_send_addr_valid, all_vld()}), 160'(0));
    end
    chk("post_rst_pr_rdy", 160'(receive_pr_ready), 160'(1));
    run_vec(1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/packet_loader.md
PACKET_LOADER -- requirements
Module: packet_loader

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 CLK  in  1  clock; all state changes on rising edge.
REQ-003 RST  in  1  asynchronous active-low reset.
REQ-004 OPADDR  in  32  byte base address of the packet image in memory.
REQ-005 MEM_SEND_ADDR_VALID / MEM_SEND_ADDR  out  1/32  memory read-address request.
REQ-006 MEM_SEND_DATA_VALID / MEM_SEND_DATA  out  1/32  write channel; both held 0 permanently (block is read-only).
REQ-007 MEM_SEND_READY  in  1  memory accepts address.
REQ-008 MEM_RECEIVE_VALID / MEM_RECEIVE_DATA / MEM_RECEIVE_READY  in/in/out  1/32/1  read-data return.
REQ-009 RECEIVE_PR_VALID / RECEIVE_PR_DATA / RECEIVE_PR_READY  in/in/out  1/PACKET_REQUEST_WIDTH/1  packet-request input.
REQ-010 SEND_PC_TO_QU_*, SEND_PC_TO_FE_*, SEND_PC_TO_MA_*  VALID out 1, DATA out PACKET_WIDTH, READY in 1  packet outputs to queue, fetch, matching units.

Function
REQ-011 All channels: a transfer occurs on a rising edge where VALID and READY are both 1; a raised VALID and its DATA SHALL stay stable until that transfer.
REQ-012 Request layout (99 bits, MSB first): dest_option[2:0], dest_addr[15:0], color[15:0], data_a[31:0], data_b[31:0].
REQ-013 Packet layout (160 bits): [159:158] opmode, [157:152] opcode, [151:144] reserved, [143:128] color, [127:96] data_1, [95:64] data_2, [63:32] data_3, [31:0] destination fields.
REQ-014 FSM states: IDLE, ADDR, DATA, SEND.
REQ-015 IDLE: RECEIVE_PR_READY=1; on request transfer, latch request, clear word counter k=0, go to ADDR.
REQ-016 ADDR: MEM_SEND_ADDR_VALID=1, MEM_SEND_ADDR = OPADDR + zero-extended dest_addr + 4*k (32-bit modulo wrap); on transfer go to DATA.
REQ-017 DATA: MEM_RECEIVE_READY=1; on transfer store word into packet bits [159-32k -: 32]; if k<4, k+1 and return to ADDR; if k=4, go to SEND.
REQ-018 Exactly five reads per request, strictly one outstanding, addresses ascending by 4.
REQ-019 SEND: merged packet driven on the port selected by opmode: OPCODE_EI(0)->QU, OPCODE_FN(1)->FE, OPCODE_MA(2)->MA; only that port's VALID=1; on transfer return to IDLE.
REQ-020 opmode 3: packet SHALL be discarded with no output, return to IDLE.
REQ-021 Merge: color <- request color; DEST_OPTION_EXEC(0): data_1<-data_a, data_2<-data_b; DEST_OPTION_ONE(1): data_1<-data_a; DEST_OPTION_LEFT(2): data_1<-data_a; DEST_OPTION_RIGHT(3): data_2<-data_a; codes 4-7 treated as EXEC; all other fields copied from memory.
REQ-022 Outputs SHALL be registered; RECEIVE_PR_READY=0 in every state except IDLE (no request buffering).
REQ-023 OPADDR sampled continuously; it SHALL be held constant by the system while busy.

Reset
REQ-024 While RST=0: state IDLE, k=0, every VALID output and MEM_RECEIVE_READY = 0, all data outputs 0.
REQ-025 RST asserted mid-operation SHALL abort the load; no partial packet is emitted after release.
REQ-026 RECEIVE_PR_READY SHALL be 0 during reset and 1 from the first edge after release.

Structure
REQ-027 Shared package: PACKET_WIDTH=160, PACKET_REQUEST_WIDTH=99, OPCODE_EI/FN/MA, DEST_OPTION_EXEC/ONE/LEFT/RIGHT, field bit ranges, and the merge function.
REQ-028 One combinational sub-module packet_merge (loaded packet + request -> output packet); FSM, counter, and registers live in packet_loader.

Verification
REQ-029 Reset with all READYs 0 -> all VALIDs 0, RECEIVE_PR_READY 0; after release RECEIVE_PR_READY 1.
REQ-030 OPADDR=0x2000_0000, dest_addr=0x0100 -> addresses 0x2000_0100, 0x104, 0x108, 0x10C, 0x110 in order, one per data return.
REQ-031 Memory words with opmode 0/1/2 -> packet only on QU/FE/MA respectively; other VALIDs stay 0.
REQ-032 dest_option 0..3 with random data -> output bits [159:16] equal the REQ-021 merge of the loaded words.
REQ-033 Random stalls on MEM_SEND_READY, MEM_RECEIVE_VALID, and output READY -> outputs held stable and the result is unchanged.
REQ-034 opmode 3 -> no output; next request accepted normally.
